// File: rtl/div_share_arbiter.sv
// Round-robin front end that shares one multi-cycle divider among NREQ issue lanes.
// A zero divisor bypasses the divider; a watchdog bounds the wait for div_valid.
module div_share_arbiter #(
  parameter int unsigned NREQ    = 2,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned MIN_LAT = 1,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ-1:0]          req_op,
  input  logic [NREQ*DATA_W-1:0]   req_a,
  input  logic [NREQ*DATA_W-1:0]   req_b,
  input  logic [NREQ*TAG_W-1:0]    req_tag,
  output logic                     div_start,
  output logic                     div_op,
  output logic [DATA_W-1:0]        div_a,
  output logic [DATA_W-1:0]        div_b,
  input  logic                     div_valid,
  input  logic [DATA_W-1:0]        div_result,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [$clog2(NREQ)-1:0]  rsp_id,
  output logic [TAG_W-1:0]         rsp_tag,
  output logic [DATA_W-1:0]        rsp_result,
  output logic                     rsp_err
);

  localparam int unsigned ID_W  = $clog2(NREQ);
  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_e;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic                op_q, op_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                err_q, err_d;

  logic                grant_found_c;
  logic [ID_W-1:0]     grant_id_c;
  logic                honoured_c;

  logic [DATA_W-1:0]   a_arr [NREQ];
  logic [DATA_W-1:0]   b_arr [NREQ];
  logic [TAG_W-1:0]    tag_arr [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign a_arr[gi]   = req_a[gi*DATA_W +: DATA_W];
    assign b_arr[gi]   = req_b[gi*DATA_W +: DATA_W];
    assign tag_arr[gi] = req_tag[gi*TAG_W +: TAG_W];
  end

  // First pending lane at or after rr_ptr, wrapping at NREQ.
  always_comb begin
    int unsigned idx;
    idx           = 0;
    grant_found_c = 1'b0;
    grant_id_c    = '0;
    for (int k = 0; k < int'(NREQ); k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!grant_found_c && req_valid[ID_W'(idx)]) begin
        grant_found_c = 1'b1;
        grant_id_c    = ID_W'(idx);
      end
    end
  end

  // MIN_LAT masks a level div_valid left over from the previous operation.
  assign honoured_c = div_valid && (wait_cnt_q >= CNT_W'(MIN_LAT));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      wait_cnt_q <= '0;
      id_q       <= '0;
      op_q       <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      tag_q      <= '0;
      result_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      wait_cnt_q <= wait_cnt_d;
      id_q       <= id_d;
      op_q       <= op_d;
      a_q        <= a_d;
      b_q        <= b_d;
      tag_q      <= tag_d;
      result_q   <= result_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    wait_cnt_d = wait_cnt_q;
    id_d       = id_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    tag_d      = tag_q;
    result_d   = result_q;
    err_d      = err_q;
    case (state_q)
      S_IDLE: begin
        if (grant_found_c) begin
          id_d       = grant_id_c;
          op_d       = req_op[grant_id_c];
          a_d        = a_arr[grant_id_c];
          b_d        = b_arr[grant_id_c];
          tag_d      = tag_arr[grant_id_c];
          err_d      = 1'b0;
          wait_cnt_d = '0;
          if (b_arr[grant_id_c] == '0) begin
            result_d = req_op[grant_id_c] ? a_arr[grant_id_c] : '1;
            state_d  = S_RESP;
          end else begin
            state_d  = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        wait_cnt_d = '0;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (honoured_c) begin
          result_d = div_result;
          err_d    = 1'b0;
          state_d  = S_RESP;
        end else if (wait_cnt_q == CNT_W'(TIMEOUT - 1)) begin
          result_d = '0;
          err_d    = 1'b1;
          state_d  = S_RESP;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          state_d  = S_IDLE;
          rr_ptr_d = (id_q == ID_W'(NREQ - 1)) ? '0 : id_q + ID_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Strobes decode straight from the state flop; payloads come from held registers.
  always_comb begin
    req_ready = '0;
    if (state_q == S_IDLE && grant_found_c) req_ready[grant_id_c] = 1'b1;
    div_start  = (state_q == S_ISSUE);
    rsp_valid  = (state_q == S_RESP);
    div_op     = op_q;
    div_a      = a_q;
    div_b      = b_q;
    rsp_id     = id_q;
    rsp_tag    = tag_q;
    rsp_result = result_q;
    rsp_err    = err_q;
  end

endmodule
